// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage state encoding and constants
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUF  = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] inst_d,
  input  logic [ADDR_W-1:0] pc4_d,
  output logic [DATA_W-1:0] inst_q,
  output logic [ADDR_W-1:0] pc4_q,
  output logic              valid_q
);

  // Flush only clears valid so ID still sees the last instruction/PC+4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS fetch stage with IF/ID register; IF_FETCH_PERF_EN adds perf counters
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              IFtoIDWrite,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemValid,
  input  logic [DATA_W-1:0] ImemData,
  output logic [DATA_W-1:0] IF_ID_Inst,
  output logic [ADDR_W-1:0] IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic              FetchBusy
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       StallCount
`endif
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, req_addr, req_addr_n, req_addr_inc;
  logic [DATA_W-1:0] buf_data, buf_data_n, id_inst;
  logic              id_load, id_flush, done, advance;

  assign ImemReq      = (state == REQ) || (state == KILL);
  assign FetchBusy    = ImemReq;
  assign ImemAddr     = req_addr;
  assign done         = ImemReq && ImemValid;
  assign advance      = IFtoIDWrite && PCWrite;
  assign req_addr_inc = req_addr + ADDR_W'(PC_INC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      buf_data <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      buf_data <= buf_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    buf_data_n = buf_data;
    id_load    = 1'b0;
    id_flush   = 1'b0;
    id_inst    = (state == BUF) ? buf_data : ImemData;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (PCSrc) begin
          pc_n       = BranchTarget;
          req_addr_n = BranchTarget;
          id_flush   = 1'b1;
        end else begin
          req_addr_n = pc;
        end
      end
      REQ: begin
        if (PCSrc) begin
          pc_n     = BranchTarget;
          id_flush = 1'b1;
          if (done) req_addr_n = BranchTarget;
          else      state_n    = KILL;
        end else if (done) begin
          if (advance) begin
            id_load    = 1'b1;
            pc_n       = req_addr_inc;
            req_addr_n = req_addr_inc;
          end else begin
            buf_data_n = ImemData;
            state_n    = BUF;
          end
        end else if (IFtoIDWrite) begin
          id_flush = 1'b1;
        end
      end
      BUF: begin
        if (PCSrc) begin
          pc_n       = BranchTarget;
          req_addr_n = BranchTarget;
          id_flush   = 1'b1;
          state_n    = REQ;
        end else if (advance) begin
          id_load    = 1'b1;
          pc_n       = req_addr_inc;
          req_addr_n = req_addr_inc;
          state_n    = REQ;
        end
      end
      KILL: begin
        // The killed request must still finish at its original address.
        if (PCSrc) begin
          pc_n     = BranchTarget;
          id_flush = 1'b1;
        end else if (done) begin
          req_addr_n = pc;
          state_n    = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (id_load),
    .flush   (id_flush),
    .inst_d  (id_inst),
    .pc4_d   (req_addr_inc),
    .inst_q  (IF_ID_Inst),
    .pc4_q   (IF_ID_PCPlus4),
    .valid_q (IF_ID_Valid)
  );

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (id_load) FetchCount <= FetchCount + 32'd1;
      if (!IFtoIDWrite || (ImemReq && !ImemValid)) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
